// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_pkg
// Purpose  : Shared types and constants for the instruction prefetch queue.
//            XLEN, the canonical NOP encoding, the buffered {pc, instr}
//            entry type, and a word-alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Purpose  : Bundles the redirect input, the imem request/grant/response bus
//            and the decode-side valid/ready handshake of fetch_queue.
// Ports    : master - fetch_queue side (drives imem_req/addr, out_*)
//            slave  - environment side (drives redirect, gnt, rvalid/rdata,
//                     out_ready)
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : DEPTH x 64-bit synchronous FIFO of fetch entries with flush.
//            Simultaneous push and pop are allowed at any occupancy that
//            makes both legal; flush wins over push and pop.
// Ports    : clk, rst (async, active-low), push, pop, flush, push_data,
//            head (zero while empty), count (occupancy)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_data,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int C_AW = $clog2(DEPTH);
  localparam int C_CW = C_AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_CW-1:0] r_cnt;
  logic            w_do_pop;
  logic            w_do_push;

  assign w_do_pop  = pop && !flush && (r_cnt != '0);
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = push && !flush && ((r_cnt != C_CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
      r_cnt <= r_cnt + C_CW'(w_do_push) - C_CW'(w_do_pop);
    end
  end

  // Storage carries no reset; the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_do_push) mem[r_wr_ptr] <= push_data;
  end

  assign head  = (r_cnt != '0) ? mem[r_rd_ptr] : '0;
  assign count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction prefetch stage. Issues sequential word fetches,
//            buffers in-order responses as {pc, instr} entries and hands
//            them to decode; a redirect flushes the buffer, discards
//            in-flight responses and restarts at the target.
// Ports    : clk, rst (async, active-low),
//            bus (fetch_queue_if.master): redirect_valid/pc, imem_req/addr/
//            gnt/rvalid/rdata, out_valid/ready/pc/instr
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.master bus
);

  localparam int C_CW = $clog2(DEPTH) + 1;
  localparam int C_OW = $clog2(MAX_OUT) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  // r_outst counts every granted request not yet answered, including those
  // already marked for discard. Credits therefore bound the total number of
  // responses in flight, and r_discard_cnt can never exceed r_outst.
  logic [C_OW-1:0] r_outst;
  logic [C_OW-1:0] r_discard_cnt;

  logic [C_CW-1:0] w_occ;
  logic            w_req;
  logic            w_gnt_fire;
  logic            w_drop;
  logic            w_push;
  logic            w_pop;
  logic            w_out_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  assign w_req = rst && !bus.redirect_valid
              && (r_outst < C_OW'(MAX_OUT))
              && ((32'(w_occ) + 32'(r_outst)) < 32'(DEPTH));

  assign w_gnt_fire  = w_req && bus.imem_gnt;
  assign w_drop      = (r_discard_cnt != '0);
  assign w_push      = bus.imem_rvalid && !w_drop && !bus.redirect_valid;
  assign w_out_valid = (w_occ != '0) && !bus.redirect_valid;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_push_data = '{pc: r_resp_pc, instr: bus.imem_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outst       <= '0;
      r_discard_cnt <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc    <= word_align(bus.redirect_pc);
      r_resp_pc     <= word_align(bus.redirect_pc);
      // Everything still in flight after this cycle belongs to the old path.
      r_outst       <= r_outst - C_OW'(bus.imem_rvalid);
      r_discard_cnt <= r_outst - C_OW'(bus.imem_rvalid);
    end else begin
      if (w_gnt_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_push)     r_resp_pc  <= r_resp_pc + 32'd4;
      r_outst <= r_outst + C_OW'(w_gnt_fire) - C_OW'(bus.imem_rvalid);
      if (bus.imem_rvalid && w_drop) r_discard_cnt <= r_discard_cnt - C_OW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .flush     (bus.redirect_valid),
    .push_data (w_push_data),
    .head      (w_head),
    .count     (w_occ)
  );

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst) bus.imem_rvalid |-> (r_outst != '0)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Randomised scoreboard bench for fetch_queue. A memory model
//            grants and answers requests; an expected-stream model predicts
//            request addresses, credits and the decode-side entry sequence.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          ready_cyc;
    int          epoch;
  } pend_t;

  int           n_checks  = 0;
  int           n_pass    = 0;
  int           pops_seen = 0;
  int           cyc       = 0;
  int           epoch     = 0;
  int           buf_cnt   = 0;   // delivered entries not yet popped
  int           max_lat   = 0;
  logic [31:0]  model_pc  = RESET_PC;
  pend_t        pend[$];         // memory side: granted, not yet answered
  fetch_entry_t sb[$];           // decode side: expected entries in order
  logic         force_redir = 1'b0;
  logic [31:0]  force_tgt   = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'hDEAD_0000;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every accepted output must be the next expected entry.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got pop of pc %h expected no entry", bus.out_pc);
      end else begin
        e = sb.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("out_instr", bus.out_instr, e.instr);
        pops_seen++;
      end
    end
  end

  task automatic drive_idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic model_reset();
    epoch++;
    model_pc = RESET_PC;
    sb.delete();
    pend.delete();
    buf_cnt = 0;
  endtask

  // One clock cycle: check at the negedge, update the model after the edge,
  // then drive the next cycle's inputs (percent probabilities).
  task automatic step(input int pg, input int pr, input int prv, input int pred);
    logic        redir, rv, fire, pop, exp_req;
    logic [31:0] tgt, addr;
    pend_t       pe;
    @(negedge clk);
    redir   = bus.redirect_valid;
    tgt     = bus.redirect_pc;
    rv      = bus.imem_rvalid;
    addr    = bus.imem_addr;
    exp_req = !redir && (pend.size() < MAX_OUT) && ((buf_cnt + pend.size()) < DEPTH);
    check("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check("out_valid", 32'(bus.out_valid), 32'((buf_cnt > 0) && !redir));
    fire = bus.imem_req && bus.imem_gnt;
    if (fire) check("imem_addr", addr, model_pc);
    pop = (buf_cnt > 0) && !redir && bus.out_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (rv && pend.size() > 0) begin
      pe = pend.pop_front();
      if (!redir && pe.epoch == epoch) buf_cnt++;
    end
    if (pop) buf_cnt--;
    if (fire) begin
      pend.push_back('{addr, cyc + $urandom_range(0, max_lat), epoch});
      sb.push_back('{pc: model_pc, instr: mem_data(model_pc)});
      model_pc += 32'd4;
    end
    if (redir) begin
      epoch++;
      model_pc = {tgt[31:2], 2'b00};
      sb.delete();
      buf_cnt = 0;
    end
    bus.imem_gnt  = ($urandom_range(0, 99) < pg);
    bus.out_ready = ($urandom_range(0, 99) < pr);
    if (force_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = force_tgt;
      force_redir        = 1'b0;
    end else begin
      bus.redirect_valid = ($urandom_range(0, 99) < pred);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                        : $urandom;
    end
    if (pend.size() > 0 && pend[0].ready_cyc <= cyc && $urandom_range(0, 99) < prv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_data(pend[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
    end
  endtask

  task automatic run(input int n, input int pg, input int pr, input int prv, input int pred);
    for (int i = 0; i < n; i++) step(pg, pr, prv, pred);
  endtask

  initial begin
    drive_idle();
    #2;
    check("reset_imem_req", 32'(bus.imem_req), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_pc", bus.out_pc, 32'd0);
    check("reset_out_instr", bus.out_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.imem_gnt  = 1'b1;
    bus.out_ready = 1'b1;

    // Streaming with immediate grants and single-cycle responses.
    max_lat = 0;
    run(20, 100, 100, 100, 0);
    // Decode stalled: credits stop requests once the buffer would fill.
    run(10, 100, 0, 100, 0);
    run(15, 100, 100, 100, 0);

    // Redirect with misaligned target while stalled and responses in flight.
    max_lat = 2;
    run(3, 100, 0, 100, 0);
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0102;
    run(20, 100, 100, 100, 0);

    // Redirect to the top of the address space: PCs wrap to zero.
    force_redir = 1'b1;
    force_tgt   = 32'hFFFF_FFFC;
    max_lat = 0;
    run(20, 100, 100, 100, 0);

    // Random traffic with frequent redirects and variable latency.
    max_lat = 3;
    run(3000, 60, 60, 70, 4);
    run(500, 90, 90, 90, 15);

    // Asynchronous reset in the middle of a burst.
    run(5, 100, 0, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_pc", bus.out_pc, 32'd0);
    check("async_rst_out_instr", bus.out_instr, 32'd0);
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.imem_gnt  = 1'b1;
    bus.out_ready = 1'b1;
    max_lat = 1;
    run(300, 70, 70, 80, 2);

    check("pops_seen_enough", 32'(pops_seen > 200), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
